offchip_link_tx: RTL

Core-side transmit stage of the off-chip link. It sits directly upstream of the per-channel downstream receivers.
- Accepts 8-bit words from the core with a valid/ready handshake.
- Serializes each word into two beats across two 2-bit I/O channels.
- Gates transmission on a credit count that is replenished by toggle-encoded tokens returned from the receiver.
- Default CREDITS matches the receiver buffer depth of 8 entries.

---
 rtl/offchip_link_pkg.sv | 36 +++
 rtl/offchip_credit_counter.sv | 73 +++++++
 rtl/offchip_link_tx.sv | 133 +++++++++++++
 3 files changed

// File: rtl/offchip_link_pkg.sv
// ---------------------------------------------------------------------------
// offchip_link_pkg
// Shared definitions for the off-chip link, used by both the transmit stage
// and the receiver side.
//   link_state_t    : serializer state encoding
//   LANE_W          : bits per channel per beat
//   NUM_CH          : number of I/O channels
//   BEATS_PER_WORD  : beats needed to move one core word
//   DEFAULT_CREDITS : default receiver buffer depth (credit pool size)
//   lane_slice()    : picks the bits of a word carried on one channel/beat
// ---------------------------------------------------------------------------
package offchip_link_pkg;

    localparam int LANE_W          = 2;
    localparam int NUM_CH          = 2;
    localparam int BEATS_PER_WORD  = 2;
    localparam int WORD_W          = LANE_W * NUM_CH * BEATS_PER_WORD;
    localparam int DEFAULT_CREDITS = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } link_state_t;

    // Beat b carries the word bits [(b*NUM_CH+ch)*LANE_W +: LANE_W] on channel
    // ch, so beat 0 takes the low nibble with channel 0 on the lowest lane.
    function automatic logic [LANE_W-1:0] lane_slice(
        input logic [WORD_W-1:0] word,
        input int                beat,
        input int                ch
    );
        return word[(beat * NUM_CH + ch) * LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/offchip_credit_counter.sv
// ---------------------------------------------------------------------------
// offchip_credit_counter
// Credit pool for the link transmitter. Returned credits arrive as a
// toggle-encoded token: every change of token_in is one credit. The pool is a
// saturating up/down counter starting full; a credit arriving while the pool
// is already full is a protocol error and raises a sticky flag.
//   clk      : link clock
//   rst      : asynchronous active-high reset
//   accept   : a word is being accepted this cycle (consumes one credit)
//   token_in : toggle-encoded credit return from the receiver
//   credits  : current credit count
//   err_ovf  : sticky; credit returned while pool already full
// ---------------------------------------------------------------------------
module offchip_credit_counter
    import offchip_link_pkg::*;
#(
    parameter  int CREDITS = DEFAULT_CREDITS,
    localparam int CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic             token_in,
    output logic [CNT_W-1:0] credits,
    output logic             err_ovf
);

    localparam logic [CNT_W-1:0] CREDITS_MAX = CNT_W'(CREDITS);

    logic             tok_q;
    logic             ret;
    logic [CNT_W-1:0] credits_q;
    logic [CNT_W-1:0] credits_nxt;
    logic             err_q;
    logic             err_nxt;

    // Either edge of the token is a credit; at most one per cycle.
    assign ret = token_in ^ tok_q;

    always_comb begin
        credits_nxt = credits_q;
        err_nxt     = err_q;
        if (accept && !ret) begin
            // accept is gated by credits != 0 upstream; guard anyway so the
            // counter can never wrap below zero.
            if (credits_q != '0) begin
                credits_nxt = credits_q - 1'b1;
            end
        end else if (!accept && ret) begin
            if (credits_q == CREDITS_MAX) begin
                err_nxt = 1'b1;
            end else begin
                credits_nxt = credits_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tok_q     <= 1'b0;
            credits_q <= CREDITS_MAX;
            err_q     <= 1'b0;
        end else begin
            tok_q     <= token_in;
            credits_q <= credits_nxt;
            err_q     <= err_nxt;
        end
    end

    assign credits = credits_q;
    assign err_ovf = err_q;

endmodule

// File: rtl/offchip_link_tx.sv
// ---------------------------------------------------------------------------
// offchip_link_tx
// Core-side transmit stage of the off-chip link. Accepts 8-bit words with a
// valid/ready handshake and sends each as two beats over two 2-bit channels,
// gated by a credit pool that the receiver refills with toggle tokens.
//   clk             : link clock
//   rst             : asynchronous active-high reset
//   core_valid_in   : core word valid
//   core_data_in    : core word
//   core_ready_out  : block can accept a word this cycle
//   io_token_in     : credit return, each toggle is one credit
//   io_valid_out    : beat valid on both channels
//   io_data_out_ch0 : channel 0 lane
//   io_data_out_ch1 : channel 1 lane
//   credit_cnt_out  : current credit count
//   err_credit_ovf  : sticky credit overflow flag
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | nothing on the wire; ready if credits remain
// SEND_LO | low beat (bits 3:0) on the wire; not ready
// SEND_HI | high beat (bits 7:4) on the wire; ready so words stream back
//         | to back at one word per two cycles
// ---------------------------------------------------------------------------
module offchip_link_tx
    import offchip_link_pkg::*;
#(
    parameter  int CREDITS = DEFAULT_CREDITS,
    localparam int CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_valid_in,
    input  logic [7:0]        core_data_in,
    output logic              core_ready_out,
    input  logic              io_token_in,
    output logic              io_valid_out,
    output logic [LANE_W-1:0] io_data_out_ch0,
    output logic [LANE_W-1:0] io_data_out_ch1,
    output logic [CNT_W-1:0]  credit_cnt_out,
    output logic              err_credit_ovf
);

    link_state_t       state_q;
    link_state_t       state_nxt;
    logic [7:0]        data_q;
    logic [7:0]        data_nxt;
    logic              valid_q;
    logic              valid_nxt;
    logic [LANE_W-1:0] ch0_q;
    logic [LANE_W-1:0] ch0_nxt;
    logic [LANE_W-1:0] ch1_q;
    logic [LANE_W-1:0] ch1_nxt;
    logic [CNT_W-1:0]  credits;
    logic              accept;

    // Ready depends only on registers, never on core_valid_in, so a credit
    // returned in the zero-credit cycle shows up as ready one cycle later.
    assign core_ready_out = (state_q != SEND_LO) && (credits != '0);
    assign accept         = core_valid_in && core_ready_out;

    offchip_credit_counter #(
        .CREDITS (CREDITS)
    ) u_credit_counter (
        .clk      (clk),
        .rst      (rst),
        .accept   (accept),
        .token_in (io_token_in),
        .credits  (credits),
        .err_ovf  (err_credit_ovf)
    );

    // The lanes are registered so the beat for a state is already on the
    // wire during that state: the accept edge loads the low beat, the
    // SEND_LO edge loads the high beat. In IDLE the lanes keep their last
    // value and only valid drops.
    always_comb begin
        state_nxt = state_q;
        data_nxt  = data_q;
        valid_nxt = 1'b0;
        ch0_nxt   = ch0_q;
        ch1_nxt   = ch1_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_nxt = SEND_LO;
                end
            end
            SEND_LO: begin
                state_nxt = SEND_HI;
                valid_nxt = 1'b1;
                ch0_nxt   = lane_slice(data_q, 1, 0);
                ch1_nxt   = lane_slice(data_q, 1, 1);
            end
            SEND_HI: begin
                state_nxt = accept ? SEND_LO : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (accept) begin
            data_nxt  = core_data_in;
            valid_nxt = 1'b1;
            ch0_nxt   = lane_slice(core_data_in, 0, 0);
            ch1_nxt   = lane_slice(core_data_in, 0, 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            ch0_q   <= '0;
            ch1_q   <= '0;
        end else begin
            state_q <= state_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            ch0_q   <= ch0_nxt;
            ch1_q   <= ch1_nxt;
        end
    end

    assign io_valid_out    = valid_q;
    assign io_data_out_ch0 = ch0_q;
    assign io_data_out_ch1 = ch1_q;
    assign credit_cnt_out  = credits;

endmodule
